// File: rtl/nes_pixel_colorizer_pkg.sv
// Shared definitions for the NES colour stage: 2C02 system palette, fade state
// encoding and the index darkening helper.
package nes_pkg;

  localparam logic [5:0] NES_BLACK = 6'h0F;
  localparam logic [2:0] MAX_FADE  = 3'd4;

  typedef enum logic [1:0] {
    FADE_IDLE,
    FADE_OUT,
    FADE_DARK,
    FADE_IN
  } fade_state_t;

  localparam logic [23:0] SYS_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0058F8, 24'h4040FC, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  // Columns E/F are black on the 2C02; darkening drops whole luma rows.
  function automatic logic [5:0] fade_index(input logic [5:0] idx, input logic [2:0] lvl);
    logic [2:0] luma;
    luma = {1'b0, idx[5:4]};
    if (idx[3:0] >= 4'hE || luma < lvl)
      return NES_BLACK;
    else
      return {2'(luma - lvl), idx[3:0]};
  endfunction

endpackage

// File: rtl/nes_sys_palette.sv
// Combinational 6-bit NES colour index to 24-bit RGB lookup.
module nes_sys_palette
  import nes_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [23:0] rgb
);

  assign rgb = SYS_PALETTE[idx];

endmodule

// File: rtl/nes_pixel_colorizer.sv
// Two-stage NES pixel colour pipeline: palette address, optional frame-stepped
// fade, system-palette RGB. Fade logic built only when PALETTE_FADE_EN is defined.
module nes_pixel_colorizer
  import nes_pkg::*;
#(
  parameter int RGB_W    = 4,
  parameter int FADE_FRM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic             in_blank,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [1:0]       in_pix,
  input  logic [1:0]       in_pal,
  input  logic             in_spr,
  output logic [4:0]       pal_addr,
  input  logic [7:0]       pal_dout,
  input  logic             frame_tick,
  input  logic             fade_out_req,
  input  logic             fade_in_req,
  output logic             fade_busy,
  output logic [2:0]       fade_level,
  output logic             out_vld,
  output logic             out_hs,
  output logic             out_vs,
  output logic [RGB_W-1:0] out_r,
  output logic [RGB_W-1:0] out_g,
  output logic [RGB_W-1:0] out_b
);

  logic [5:0]  idx1;
  logic        vld1, blank1, hs1, vs1;
  logic [5:0]  idx_faded;
  logic [23:0] rgb24;
  logic        unused_bits;

  // Colour 0 of every palette shows the universal backdrop.
  assign pal_addr = (in_pix == 2'd0) ? 5'h00 : {in_spr, in_pal, in_pix};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx1   <= '0;
      vld1   <= 1'b0;
      blank1 <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
    end else begin
      idx1   <= pal_dout[5:0];
      vld1   <= in_vld;
      blank1 <= in_blank;
      hs1    <= in_hs;
      vs1    <= in_vs;
    end
  end

`ifdef PALETTE_FADE_EN
  fade_state_t state;
  logic [2:0]  level;
  logic [7:0]  frm_cnt;

  assign fade_level = level;
  assign fade_busy  = (state == FADE_OUT) || (state == FADE_IN);
  assign unused_bits = ^pal_dout[7:6];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FADE_IDLE;
      level   <= '0;
      frm_cnt <= '0;
    end else if (fade_out_req && (state == FADE_IDLE || state == FADE_IN ||
                                  (state == FADE_OUT && fade_in_req))) begin
      state   <= FADE_OUT;
      frm_cnt <= '0;
    end else if (fade_in_req && (state == FADE_DARK || state == FADE_OUT)) begin
      state   <= FADE_IN;
      frm_cnt <= '0;
    end else if (frame_tick && fade_busy) begin
      if (frm_cnt == 8'(FADE_FRM - 1)) begin
        frm_cnt <= '0;
        if (state == FADE_OUT) begin
          level <= level + 3'd1;
          if (level + 3'd1 == MAX_FADE) state <= FADE_DARK;
        end else begin
          level <= level - 3'd1;
          if (level == 3'd1) state <= FADE_IDLE;
        end
      end else begin
        frm_cnt <= frm_cnt + 8'd1;
      end
    end
  end
`else
  assign fade_level  = '0;
  assign fade_busy   = 1'b0;
  assign unused_bits = ^{pal_dout[7:6], frame_tick, fade_out_req, fade_in_req, 8'(FADE_FRM)};
`endif

  assign idx_faded = fade_index(idx1, fade_level);

  nes_sys_palette u_sys_palette (
    .idx (idx_faded),
    .rgb (rgb24)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
      out_r   <= '0;
      out_g   <= '0;
      out_b   <= '0;
    end else begin
      out_vld <= vld1;
      out_hs  <= hs1;
      out_vs  <= vs1;
      if (vld1 && !blank1) begin
        out_r <= rgb24[23 -: RGB_W];
        out_g <= rgb24[15 -: RGB_W];
        out_b <= rgb24[7 -: RGB_W];
      end else begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end
    end
  end

endmodule
